// File: rtl/ahb_lite_cmd_master.sv
// Command-stream to AHB-Lite single-transfer master; NONSEQ one cycle after accept, response two cycles after that with zero waits.
// Credit-limited by RSP_DEPTH; define AHB_MASTER_PIPELINE_EN to overlap a new address phase with the previous data phase.
module ahb_lite_cmd_master #(
    parameter int unsigned RSP_DEPTH = 2,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [63:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {BUS_RUN, BUS_ERR2} bus_st_t;

    bus_st_t        bus_st;
    bus_st_t        bus_st_nxt;
    logic           a_vld;
    logic           d_vld;
    logic           d_write;
    logic [63:0]    a_wdata;
    logic           accept;
    logic           a_done;
    logic           d_done;
    logic           slot_ok;
    logic           push;
    logic           pop;
    logic [1:0]     sz_clamp;
    logic [31:0]    addr_aligned;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW:0]    outstanding;
    logic [63:0]    fifo_rdata [RSP_DEPTH];
    logic           fifo_write [RSP_DEPTH];
    logic           fifo_err   [RSP_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        sz_clamp = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];
        case (sz_clamp)
            2'd0:    addr_aligned = cmd_addr;
            2'd1:    addr_aligned = {cmd_addr[31:1], 1'b0};
            2'd2:    addr_aligned = {cmd_addr[31:2], 2'b0};
            default: addr_aligned = {cmd_addr[31:3], 3'b0};
        endcase
    end

    // The held address phase must not advance during the forced-IDLE error cycle.
    always_comb begin
        outstanding = {1'b0, count} + {{CW{1'b0}}, a_vld} + {{CW{1'b0}}, d_vld};
        a_done      = a_vld && HREADY && !HRESP && (bus_st == BUS_RUN);
        d_done      = d_vld && HREADY;
`ifdef AHB_MASTER_PIPELINE_EN
        slot_ok     = !a_vld || a_done;
`else
        slot_ok     = !a_vld && (!d_vld || d_done);
`endif
        cmd_ready   = !HRESET && (outstanding < (CW+1)'(RSP_DEPTH)) && slot_ok;
        accept      = cmd_valid && cmd_ready;
        push        = d_done;
        pop         = rsp_valid && rsp_ready;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bus_st <= BUS_RUN;
        end else begin
            bus_st <= bus_st_nxt;
        end
    end

    always_comb begin
        bus_st_nxt = bus_st;
        case (bus_st)
            BUS_RUN:  if (d_vld && HRESP && !HREADY) bus_st_nxt = BUS_ERR2;
            BUS_ERR2: if (HREADY) bus_st_nxt = BUS_RUN;
            default:  bus_st_nxt = BUS_RUN;
        endcase
    end

    always_comb begin
        HTRANS = (a_vld && bus_st == BUS_RUN) ? 2'b10 : 2'b00;
        HSEL   = (HTRANS != 2'b00);
        HBURST = 3'b000;
        HPROT  = HPROT_VAL;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld   <= 1'b0;
            d_vld   <= 1'b0;
            d_write <= 1'b0;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= '0;
            a_wdata <= '0;
            HWDATA  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                a_vld   <= 1'b1;
                HADDR   <= addr_aligned;
                HWRITE  <= cmd_write;
                HSIZE   <= {1'b0, sz_clamp};
                a_wdata <= cmd_wdata;
            end else if (a_done) begin
                a_vld <= 1'b0;
            end

            if (a_done) begin
                d_vld   <= 1'b1;
                d_write <= HWRITE;
                HWDATA  <= a_wdata;
            end else if (d_done) begin
                d_vld <= 1'b0;
            end

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push && !HRESET) begin
            fifo_rdata[wr_ptr] <= (d_write || HRESP) ? 64'd0 : HRDATA;
            fifo_write[wr_ptr] <= d_write;
            fifo_err[wr_ptr]   <= HRESP;
        end
    end

    always_comb begin
        rsp_valid = (count != '0);
        rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : 64'd0;
        rsp_write = rsp_valid ? fifo_write[rd_ptr] : 1'b0;
        rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;
    end

endmodule
